// File: rtl/peach_lsu_if.sv
// Core-side request/response and memory-side bus of the peach load/store unit.
// slave = LSU view, master = the environment (core plus memory) driving it.
interface peach_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/peach_lsu.sv
// RV32I load/store unit: one outstanding access, word-addressed memory bus with
// byte enables, load extraction/extension and a bounded wait for mem_ack.
module peach_lsu #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      reset,
    peach_lsu_if.slave bus
);
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic [2:0]    funct3_q;
    logic [1:0]    lane_q;
    logic          we_q;
    logic          illegal;
    logic          tmo_hit;
    logic [3:0]    be_nxt;
    logic [31:0]   wdata_nxt;

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        illegal = 1'b0;
        if (bus.req_we ? (bus.req_funct3 >= 3'd3)
                       : (bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6 || bus.req_funct3 == 3'd7))
            illegal = 1'b1;
        else if (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0])
            illegal = 1'b1;
        else if (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0)
            illegal = 1'b1;
    end

    // Store data is replicated across lanes so memory can take any enabled byte as-is.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = '0;
        if (bus.req_we) begin
            case (bus.req_funct3[1:0])
                2'd0: begin
                    be_nxt    = 4'b0001 << bus.req_addr[1:0];
                    wdata_nxt = {4{bus.req_wdata[7:0]}};
                end
                2'd1: begin
                    be_nxt    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{bus.req_wdata[15:0]}};
                end
                default: wdata_nxt = bus.req_wdata;
            endcase
        end
    end

    assign tmo_hit = (tmo_cnt == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nxt = illegal ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack || tmo_hit)
                    state_nxt = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            funct3_q       <= '0;
            lane_q         <= '0;
            we_q           <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= '0;
            bus.mem_wdata  <= '0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && bus.req_valid) begin
                funct3_q <= bus.req_funct3;
                lane_q   <= bus.req_addr[1:0];
                we_q     <= bus.req_we;
                if (!illegal) begin
                    bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                    bus.mem_we    <= bus.req_we;
                    bus.mem_be    <= be_nxt;
                    bus.mem_wdata <= wdata_nxt;
                end
            end

            if (state != ACCESS)
                tmo_cnt <= '0;
            else if (!bus.mem_ack)
                tmo_cnt <= tmo_cnt + 1'b1;

            // Response fields are only non-zero during the single RESP cycle.
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            if (state == IDLE && bus.req_valid && illegal)
                bus.resp_err <= 1'b1;
            if (state == ACCESS) begin
                if (bus.mem_ack) begin
                    if (!we_q)
                        bus.resp_rdata <= load_extract(funct3_q, lane_q, bus.mem_rdata);
                end else if (tmo_hit) begin
                    bus.resp_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_peach_lsu.sv
// Bench for peach_lsu: directed vector table, hand-written reset/back-to-back
// sequences and random transactions against an arithmetic reference model.
module tb_peach_lsu;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    peach_lsu_if bus();

    peach_lsu #(.MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_acc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: sizes, offsets and lane positions by plain arithmetic.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                                  output logic err, output logic [31:0] rd, output logic [3:0] be,
                                  output logic [31:0] wd, output logic acc);
        int unsigned off, size;
        logic        legal_code, bad;
        logic [31:0] v;
        off        = addr % 4;
        size       = 1 << (f3 % 4);
        legal_code = we ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        bad        = !legal_code || (off % size != 0);
        acc        = !bad;
        err        = bad || (dly >= TMO);
        be         = 4'hF;
        wd         = '0;
        rd         = '0;
        if (we && !bad) begin
            be = 4'((((1 << size) - 1) << off) & 15);
            for (int i = 0; i < 4; i++)
                wd[8*i +: 8] = wdata[8*(i % size) +: 8];
        end
        if (!we && !err) begin
            v = rdata >> (8 * off);
            if (size < 4) begin
                v = v & ((32'd1 << (8 * size)) - 1);
                if (f3 < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
            end
            rd = v;
        end
    endfunction

    task automatic do_txn(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                          input int dly, input logic e_err, input logic [31:0] e_rdata,
                          input logic [3:0] e_be, input logic [31:0] e_wdata, input logic e_acc);
        logic acked;
        chk({nm, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        step();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        if (e_acc) begin
            acked = 1'b0;
            for (int c = 0; c < TMO && !acked; c++) begin
                chk({nm, " mem_req"}, 32'(bus.mem_req), 32'd1);
                chk({nm, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
                chk({nm, " mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
                chk({nm, " mem_we"}, 32'(bus.mem_we), 32'(we));
                chk({nm, " mem_be"}, 32'(bus.mem_be), 32'(e_be));
                if (we) chk({nm, " mem_wdata"}, bus.mem_wdata, e_wdata);
                if (c == dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                    acked         = 1'b1;
                end else begin
                    bus.mem_rdata = $urandom;
                end
                step();
                bus.mem_ack = 1'b0;
            end
        end
        chk({nm, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({nm, " resp_err"}, 32'(bus.resp_err), 32'(e_err));
        chk({nm, " resp_rdata"}, bus.resp_rdata, e_rdata);
        chk({nm, " mem_req resp"}, 32'(bus.mem_req), 32'd0);
        step();
        chk({nm, " resp_valid done"}, 32'(bus.resp_valid), 32'd0);
        chk({nm, " req_ready after"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic        we, e_err, e_acc;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata, e_rdata, e_wdata;
        logic [3:0]  e_be;
        int          dly;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        tbl.push_back('{"lb_neg",  1'b0, 3'd0, 32'h103, 32'h0,        32'h80FF1234, 0, 1'b0, 32'hFFFFFF80, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{"sh_hi",   1'b1, 3'd1, 32'h202, 32'h0000BEEF, 32'h0,        0, 1'b0, 32'h0,        4'hC, 32'hBEEFBEEF, 1'b1});
        tbl.push_back('{"lw_mis",  1'b0, 3'd2, 32'h301, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{"lhu_tmo", 1'b0, 3'd5, 32'h402, 32'h0,        32'h0,        9, 1'b1, 32'h0,        4'hF, 32'h0,        1'b1});
        tbl.push_back('{"lbu_l1",  1'b0, 3'd4, 32'h101, 32'h0,        32'h12345678, 1, 1'b0, 32'h00000056, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{"lh_last", 1'b0, 3'd1, 32'h102, 32'h0,        32'h80017FFF, 3, 1'b0, 32'hFFFF8001, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{"lhu_hi",  1'b0, 3'd5, 32'h102, 32'h0,        32'h80017FFF, 2, 1'b0, 32'h00008001, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{"lw_ok",   1'b0, 3'd2, 32'h400, 32'h0,        32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{"sb_l3",   1'b1, 3'd0, 32'h003, 32'h123456AB, 32'h0,        1, 1'b0, 32'h0,        4'h8, 32'hABABABAB, 1'b1});
        tbl.push_back('{"sw_ok",   1'b1, 3'd2, 32'h010, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 1'b0, 32'h0,        4'hF, 32'hCAFEF00D, 1'b1});
        tbl.push_back('{"sw_tmo",  1'b1, 3'd2, 32'h020, 32'h00000001, 32'h0,        9, 1'b1, 32'h0,        4'hF, 32'h00000001, 1'b1});
        tbl.push_back('{"lh_mis",  1'b0, 3'd1, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{"ld_f3_3", 1'b0, 3'd3, 32'h000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{"ld_f3_6", 1'b0, 3'd6, 32'h000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{"st_f3_4", 1'b1, 3'd4, 32'h000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{"sh_mis",  1'b1, 3'd1, 32'h201, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{"lb_pos",  1'b0, 3'd0, 32'h100, 32'h0,        32'h0000007F, 0, 1'b0, 32'h0000007F, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{"lbu_l2",  1'b0, 3'd4, 32'h102, 32'h0,        32'hAABBCCDD, 0, 1'b0, 32'h000000BB, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{"sh_lo",   1'b1, 3'd1, 32'h200, 32'h1234ABCD, 32'h0,        0, 1'b0, 32'h0,        4'h3, 32'hABCDABCD, 1'b1});

        // Reset values
        step(); step();
        chk("rst req_ready",  32'(bus.req_ready), 32'd1);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst resp_err",   32'(bus.resp_err), 32'd0);
        chk("rst resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst mem_req",    32'(bus.mem_req), 32'd0);
        chk("rst mem_we",     32'(bus.mem_we), 32'd0);
        chk("rst mem_be",     32'(bus.mem_be), 32'd0);
        chk("rst mem_addr",   bus.mem_addr, 32'd0);
        chk("rst mem_wdata",  bus.mem_wdata, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            do_txn(tbl[i].name, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                   tbl[i].dly, tbl[i].e_err, tbl[i].e_rdata, tbl[i].e_be, tbl[i].e_wdata, tbl[i].e_acc);

        // Stray mem_ack while idle does nothing
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555AAAA;
        step();
        bus.mem_ack = 1'b0;
        chk("idle_ack resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("idle_ack mem_req", 32'(bus.mem_req), 32'd0);

        // Reset in the middle of an access
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h500;
        step();
        bus.req_valid = 1'b0;
        chk("mid_rst mem_req before", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b0;
        #1 chk("mid_rst mem_req async", 32'(bus.mem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst no resp", 32'(bus.resp_valid), 32'd0);
        end
        reset = 1'b1;
        do_txn("post_rst_lw", 1'b0, 3'd2, 32'h600, 32'h0, 32'h01020304, 0, 1'b0, 32'h01020304, 4'hF, 32'h0, 1'b1);

        // Back-to-back loads with req_valid held high
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h700;
        step();
        bus.req_funct3 = 3'd4; bus.req_addr = 32'h803;
        chk("b2b ready access", 32'(bus.req_ready), 32'd0);
        chk("b2b addr1", bus.mem_addr, 32'h700);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11223344;
        step();
        bus.mem_ack = 1'b0;
        chk("b2b resp1 valid", 32'(bus.resp_valid), 32'd1);
        chk("b2b resp1 rdata", bus.resp_rdata, 32'h11223344);
        chk("b2b ready resp", 32'(bus.req_ready), 32'd0);
        step();
        chk("b2b ready idle", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        chk("b2b mem_req2", 32'(bus.mem_req), 32'd1);
        chk("b2b addr2", bus.mem_addr, 32'h800);
        chk("b2b ready access2", 32'(bus.req_ready), 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hF0E0D0C0;
        step();
        bus.mem_ack = 1'b0;
        chk("b2b resp2 valid", 32'(bus.resp_valid), 32'd1);
        chk("b2b resp2 rdata", bus.resp_rdata, 32'h000000F0);
        step();

        // Random transactions against the reference model
        for (int n = 0; n < 300; n++) begin
            we    = 1'($urandom);
            f3    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            dly   = $urandom_range(0, 5);
            model(we, f3, addr, wdata, rdata, dly, e_err, e_rdata, e_be, e_wdata, e_acc);
            do_txn("rand", we, f3, addr, wdata, rdata, dly, e_err, e_rdata, e_be, e_wdata, e_acc);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
